tx_axis_arbiter: RTL and testbench
==================================

// Module: tx_axis_arbiter
// PURPOSE
//  Packet-granular arbiter that shares the single AXI-Stream input of the TX MAC between N_PORTS sources
//  (e.g. user traffic, pause/control-frame generator, loopback test source). A grant is held from the first
//  beat to the accepted tlast beat, so frames are never interleaved. Sits directly upstream of tx_mac.
// PARAMETERS
//  N_PORTS          4    number of requesting AXI-Stream sources (2..8)
//  XGMII_DATA_WIDTH 32   tdata width, matches tx_mac
//  AXIS_KEEP_WIDTH  XGMII_DATA_WIDTH/8   tkeep width
//  PRIO_PORT0       1    1: port 0 has strict priority over round-robin ports; 0: all ports round-robin
// PORTS
//  i_clk            in   1                         clock
//  i_reset_n        in   1                         synchronous, active-low reset
//  s_axis_tdata     in   N_PORTS*XGMII_DATA_WIDTH  per-port data, port p at [p*W +: W]
//  s_axis_tkeep     in   N_PORTS*AXIS_KEEP_WIDTH   per-port byte enables
//  s_axis_tvalid    in   N_PORTS                   per-port valid
//  s_axis_tlast     in   N_PORTS                   per-port last beat of frame
//  s_axis_trdy      out  N_PORTS                   per-port ready
//  m_axis_tdata     out  XGMII_DATA_WIDTH          data to tx_mac
//  m_axis_tkeep     out  AXIS_KEEP_WIDTH           byte enables to tx_mac
//  m_axis_tvalid    out  1                         valid to tx_mac
//  m_axis_tlast     out  1                         last to tx_mac
//  m_axis_trdy      in   1                         ready from tx_mac
//  o_grant          out  N_PORTS                   one-hot current owner, 0 when idle
//  o_busy           out  1                         frame in progress
// BEHAVIOUR
//  - Reset (sync, active-low): state=IDLE, grant=0, rr_ptr=0; all outputs 0 (m_axis_*, s_axis_trdy, o_grant, o_busy).
//  - States: IDLE, XFER.
//  - IDLE: m_axis_tvalid=0, s_axis_trdy=0. If any s_axis_tvalid[p]: pick winner, register grant, go XFER next
//    cycle (1-cycle arbitration latency). No request: stay IDLE.
//  - Winner: if PRIO_PORT0 and tvalid[0] -> port 0. Else first requesting port searching rr_ptr, rr_ptr+1, ...
//    wrapping N_PORTS-1 -> 0 (port 0 included in search when PRIO_PORT0=0, excluded otherwise).
//  - XFER: m_axis_* = s_axis_*[grant] (combinational mux from registered grant); s_axis_trdy[grant]=m_axis_trdy,
//    all other trdy bits 0. o_busy=1, o_grant=one-hot(grant).
//  - Source tvalid drop mid-frame: pass through as m_axis_tvalid=0, grant held (no timeout).
//  - Frame end: m_axis_tvalid & m_axis_trdy & m_axis_tlast -> IDLE next cycle; rr_ptr <= grant+1 (mod N_PORTS)
//    unless grant was priority port 0, in which case rr_ptr unchanged. Mandatory idle cycle between frames.
//  - tlast on a beat not accepted (trdy=0) does not end the frame.
//  - Requests from other ports during XFER ignored; they wait, tvalid held by source per AXIS rules.
//  - tx_mac asserts trdy only after seeing tvalid and drops it on tlast; arbiter must not depend on trdy in IDLE.
//  - Reset mid-frame: grant dropped, outputs 0 next cycle; the partial frame is not resumed.
//  - tkeep/tdata are not modified or registered; zero added data latency in XFER.
// STRUCTURE
//  - tx_mac_pkg: XGMII/AXIS width constants, arb_state_t enum {IDLE, XFER}.
//  - Sub-module rr_pick: combinational masked round-robin picker (req, ptr -> idx, found); no state.
//  - Top: state/grant/rr_ptr registers, output mux, trdy demux.
// TESTING
//  1 Reset: hold i_reset_n=0 with all tvalid=1 -> m_axis_tvalid=0, s_axis_trdy=0, o_grant=0 every cycle.
//  2 Single port 2, 16-beat frame, trdy=1 -> first beat on m_axis 1 cycle after tvalid, o_grant=4'b0100,
//    16 beats byte-identical, IDLE after tlast.
//  3 Ports 1,2,3 requesting continuously (PRIO_PORT0=1) -> frame order 1,2,3,1,2,3; never interleaved.
//  4 PRIO_PORT0=1, port 0 asserts tvalid mid-frame of port 3 -> port 3 finishes, port 0 next, then port 1
//    (rr_ptr=0 after port 3 -> search skips 0).
//  5 Backpressure: m_axis_trdy toggling 1010 with tlast beat first presented when trdy=0 -> frame ends only
//    on accepted tlast; s_axis_trdy mirrors m_axis_trdy for owner only.
//  6 Reset asserted on beat 5 of 10 -> outputs 0 next cycle; after release port with tvalid is re-arbitrated
//    from rr_ptr=0.

Source files
------------

// File: rtl/tx_mac_pkg.sv
// Shared TX MAC types and widths used by the AXI-Stream front end.
package tx_mac_pkg;

    // Default datapath width, matches the XGMII side of tx_mac.
    localparam int TX_DATA_W = 32;
    localparam int TX_KEEP_W = TX_DATA_W / 8;

    // Arbiter ownership state: IDLE picks a winner, XFER holds it until tlast.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Round-robin successor of an index, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tx_axis_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or above ptr_i,
// otherwise wraps to the lowest request. Holds no state.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_found;
    logic             lo_found;

    // Scan downward so the last hit is the lowest index: lo_* is the plain
    // lowest request, hi_* the lowest request at or above the pointer.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_idx   = IDX_W'(i);
                lo_found = 1'b1;
                if (IDX_W'(i) >= ptr_i) begin
                    hi_idx   = IDX_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        idx_o   = hi_found ? hi_idx : lo_idx;
        found_o = lo_found;
    end

endmodule

// File: rtl/tx_axis_arbiter.sv
// Packet-granular AXI-Stream arbiter in front of tx_mac. One source owns the
// stream from its first beat until its tlast beat is accepted; data, keep and
// last are muxed combinationally from the registered owner (no added latency).
module tx_axis_arbiter
    import tx_mac_pkg::*;
#(
    parameter int N_PORTS          = 4,
    parameter int XGMII_DATA_WIDTH = TX_DATA_W,
    parameter int AXIS_KEEP_WIDTH  = XGMII_DATA_WIDTH / 8,
    parameter bit PRIO_PORT0       = 1'b1
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset_n,
    input  logic [N_PORTS*XGMII_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [N_PORTS*AXIS_KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [N_PORTS-1:0]                    s_axis_tvalid,
    input  logic [N_PORTS-1:0]                    s_axis_tlast,
    output logic [N_PORTS-1:0]                    s_axis_trdy,
    output logic [XGMII_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    input  logic                                  m_axis_trdy,
    output logic [N_PORTS-1:0]                    o_grant,
    output logic                                  o_busy
);

    localparam int               IDX_W    = $clog2(N_PORTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PORTS - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N_PORTS-1:0] rr_req;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_found;
    logic [IDX_W-1:0]   win_idx;
    logic               any_req;
    logic               prio_hit;
    logic               frame_end;

    logic [XGMII_DATA_WIDTH-1:0] data_arr [N_PORTS];
    logic [AXIS_KEEP_WIDTH-1:0]  keep_arr [N_PORTS];

    // Unpack the flat per-port buses so the owner can be selected by index.
    for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
        assign data_arr[p] = s_axis_tdata[p*XGMII_DATA_WIDTH +: XGMII_DATA_WIDTH];
        assign keep_arr[p] = s_axis_tkeep[p*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
    end

    // Round-robin candidates; port 0 leaves the rotation when it has strict priority.
    always_comb begin
        rr_req = s_axis_tvalid;
        if (PRIO_PORT0) rr_req[0] = 1'b0;
    end

    rr_pick #(
        .N     (N_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (rr_req),
        .ptr_i   (rr_ptr_q),
        .idx_o   (rr_idx),
        .found_o (rr_found)
    );

    // Priority port overrides the rotation; otherwise take the round-robin pick.
    always_comb begin
        prio_hit = PRIO_PORT0 && s_axis_tvalid[0];
        win_idx  = prio_hit ? '0 : rr_idx;
        any_req  = prio_hit || rr_found;
    end

    // Output mux and ready demux: everything is quiet unless a frame is owned.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_trdy   = '0;
        o_grant       = '0;
        o_busy        = 1'b0;
        if (state_q == XFER) begin
            m_axis_tdata         = data_arr[grant_q];
            m_axis_tkeep         = keep_arr[grant_q];
            m_axis_tvalid        = s_axis_tvalid[grant_q];
            m_axis_tlast         = s_axis_tlast[grant_q];
            s_axis_trdy[grant_q] = m_axis_trdy;
            o_grant[grant_q]     = 1'b1;
            o_busy               = 1'b1;
        end
    end

    // A frame ends only on an accepted tlast; a stalled tlast keeps the grant.
    assign frame_end = m_axis_tvalid && m_axis_trdy && m_axis_tlast;

    // Next state: latch a winner from IDLE, release and advance rotation on frame end.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = win_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (frame_end) begin
                    state_d = IDLE;
                    grant_d = '0;
                    // A priority frame on port 0 does not disturb the rotation.
                    if (!(PRIO_PORT0 && grant_q == '0)) begin
                        rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, owner and rotation pointer; a reset abandons any partial frame.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Directed bench for tx_axis_arbiter (N_PORTS=4, 32-bit, PRIO_PORT0=1).
// Each source emits frames whose beats encode {port, frame#, 8'hC3, beat#}.
module tb_tx_axis_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int K = 4;

    logic             i_clk = 1'b0;
    logic             i_reset_n;
    logic [N*W-1:0]   s_axis_tdata;
    logic [N*K-1:0]   s_axis_tkeep;
    logic [N-1:0]     s_axis_tvalid;
    logic [N-1:0]     s_axis_tlast;
    logic [N-1:0]     s_axis_trdy;
    logic [W-1:0]     m_axis_tdata;
    logic [K-1:0]     m_axis_tkeep;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_trdy;
    logic [N-1:0]     o_grant;
    logic             o_busy;

    int n_chk = 0;
    int n_err = 0;

    int frames_left [N];
    int len         [N];
    int beat        [N];
    int fidx        [N];
    int fsnap       [N];

    logic [36:0] log_q   [$];
    int          own_q   [$];
    int          exp_ord [$];
    int          intlv_err;
    logic        in_frm;
    int          cur_own;

    always #5 i_clk = ~i_clk;

    tx_axis_arbiter #(
        .N_PORTS          (N),
        .XGMII_DATA_WIDTH (W),
        .AXIS_KEEP_WIDTH  (K),
        .PRIO_PORT0       (1'b1)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_trdy   (s_axis_trdy),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_trdy   (m_axis_trdy),
        .o_grant       (o_grant),
        .o_busy        (o_busy)
    );

    function automatic logic [31:0] mk(input int p, input int f, input int b);
        return {8'(p), 8'(f), 8'hC3, 8'(b)};
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive_src();
        for (int p = 0; p < N; p++) begin
            s_axis_tvalid[p]       = frames_left[p] > 0;
            s_axis_tlast[p]        = beat[p] == len[p] - 1;
            s_axis_tdata[p*W +: W] = mk(p, fidx[p], beat[p]);
            s_axis_tkeep[p*K +: K] = (beat[p] == len[p] - 1) ? 4'b0111 : 4'b1111;
        end
    endtask

    task automatic clear_log();
        log_q.delete();
        own_q.delete();
        exp_ord.delete();
        intlv_err = 0;
        in_frm    = 1'b0;
        cur_own   = -1;
        for (int p = 0; p < N; p++) fsnap[p] = fidx[p];
    endtask

    // Called at a negedge: log handshakes, cross the edge, advance sources,
    // apply trdy for the new cycle, return at the next negedge.
    task automatic tick(input logic trdy);
        logic [N-1:0] acc;
        #1;
        acc = s_axis_tvalid & s_axis_trdy;
        if (m_axis_tvalid && m_axis_trdy) begin
            log_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
            if (in_frm && int'(m_axis_tdata[31:24]) != cur_own) intlv_err++;
            if (!in_frm) begin
                in_frm  = 1'b1;
                cur_own = int'(m_axis_tdata[31:24]);
            end
            if (m_axis_tlast) begin
                in_frm = 1'b0;
                own_q.push_back(cur_own);
            end
        end
        @(posedge i_clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (!i_reset_n) begin
                beat[p] = 0;
            end else if (acc[p]) begin
                if (beat[p] == len[p] - 1) begin
                    beat[p] = 0;
                    fidx[p]++;
                    frames_left[p]--;
                end else begin
                    beat[p]++;
                end
            end
        end
        m_axis_trdy = trdy;
        drive_src();
        @(negedge i_clk);
    endtask

    function automatic logic src_pending();
        logic r = 1'b0;
        for (int p = 0; p < N; p++) if (frames_left[p] > 0) r = 1'b1;
        return r;
    endfunction

    task automatic run_idle(input string tag, input int max);
        int c = 0;
        while ((src_pending() || o_busy) && c < max) begin
            tick(1'b1);
            c++;
        end
        check({tag, " timeout"}, c < max, 1);
    endtask

    // Expected stream: frames in exp_ord order, each byte-identical to what
    // its source emitted, starting from the frame counters at clear_log.
    task automatic check_stream(input string tag);
        int f [N];
        int i = 0;
        int p;
        logic [36:0] e;
        for (int q = 0; q < N; q++) f[q] = fsnap[q];
        for (int k = 0; k < exp_ord.size(); k++) begin
            p = exp_ord[k];
            check({tag, " owner"}, (k < own_q.size()) ? own_q[k] : -1, p);
            for (int b = 0; b < len[p]; b++) begin
                e = {b == len[p] - 1, (b == len[p] - 1) ? 4'b0111 : 4'b1111, mk(p, f[p], b)};
                check({tag, " beat"}, (i < log_q.size()) ? log_q[i] : '1, e);
                i++;
            end
            f[p]++;
        end
        check({tag, " nbeat"}, log_q.size(), i);
        check({tag, " nfrm"}, own_q.size(), exp_ord.size());
        check({tag, " intlv"}, intlv_err, 0);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        tick(1'b1);
        i_reset_n = 1'b1;
        tick(1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f1;
        i_reset_n   = 1'b0;
        m_axis_trdy = 1'b0;
        for (int p = 0; p < N; p++) begin
            frames_left[p] = 1;
            len[p]         = 2;
            beat[p]        = 0;
            fidx[p]        = 0;
        end
        drive_src();
        clear_log();
        @(posedge i_clk);
        @(negedge i_clk);

        // 1: reset held with every source valid
        for (int c = 0; c < 5; c++) begin
            check("t1 m_tvalid", m_axis_tvalid, 0);
            check("t1 s_trdy", s_axis_trdy, 0);
            check("t1 grant", o_grant, 0);
            check("t1 busy", o_busy, 0);
            tick(1'b1);
        end
        for (int p = 0; p < N; p++) frames_left[p] = 0;
        drive_src();
        i_reset_n = 1'b1;
        tick(1'b1);
        tick(1'b1);
        check("t1 idle", {o_busy, m_axis_tvalid, o_grant}, 0);

        // 2: single port 2, 16 beats, one cycle of arbitration latency
        clear_log();
        len[2] = 16;
        frames_left[2] = 1;
        drive_src();
        #1;
        check("t2 lat", m_axis_tvalid, 0);
        tick(1'b1);
        check("t2 first vld", m_axis_tvalid, 1);
        check("t2 grant", o_grant, 4'b0100);
        check("t2 busy", o_busy, 1);
        check("t2 s_trdy", s_axis_trdy, 4'b0100);
        check("t2 d0", m_axis_tdata, mk(2, fsnap[2], 0));
        run_idle("t2", 100);
        exp_ord.push_back(2);
        check_stream("t2");
        check("t2 grant idle", o_grant, 0);
        check("t2 busy idle", o_busy, 0);

        // 3: ports 1,2,3 requesting continuously, rotation from rr_ptr=0
        do_reset();
        clear_log();
        len[1] = 3; len[2] = 2; len[3] = 4;
        frames_left[1] = 2; frames_left[2] = 2; frames_left[3] = 2;
        drive_src();
        run_idle("t3", 200);
        exp_ord.push_back(1); exp_ord.push_back(2); exp_ord.push_back(3);
        exp_ord.push_back(1); exp_ord.push_back(2); exp_ord.push_back(3);
        check_stream("t3");

        // 4: port 0 arrives mid-frame of port 3 -> 3, then 0, then 1
        clear_log();
        len[3] = 6;
        frames_left[3] = 1;
        drive_src();
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        len[0] = 2; len[1] = 2;
        frames_left[0] = 1; frames_left[1] = 1;
        drive_src();
        #1;
        check("t4 hold grant", o_grant, 4'b1000);
        check("t4 hold s_trdy", s_axis_trdy, 4'b1000);
        run_idle("t4", 200);
        exp_ord.push_back(3); exp_ord.push_back(0); exp_ord.push_back(1);
        check_stream("t4");

        // 5: trdy 1,0,1,0,1 with tlast first shown while trdy=0
        clear_log();
        f1 = fidx[1];
        len[1] = 3;
        frames_left[1] = 1;
        drive_src();
        tick(1'b1);
        check("t5 c1 s_trdy", s_axis_trdy, 4'b0010);
        check("t5 c1 data", m_axis_tdata, mk(1, f1, 0));
        tick(1'b0);
        check("t5 c2 s_trdy", s_axis_trdy, 4'b0000);
        check("t5 c2 data", m_axis_tdata, mk(1, f1, 1));
        tick(1'b1);
        check("t5 c3 s_trdy", s_axis_trdy, 4'b0010);
        check("t5 c3 data", m_axis_tdata, mk(1, f1, 1));
        tick(1'b0);
        check("t5 c4 tlast", m_axis_tlast, 1);
        check("t5 c4 s_trdy", s_axis_trdy, 4'b0000);
        tick(1'b1);
        check("t5 c5 busy", o_busy, 1);
        check("t5 c5 data", {m_axis_tlast, m_axis_tdata}, {1'b1, mk(1, f1, 2)});
        check("t5 c5 s_trdy", s_axis_trdy, 4'b0010);
        tick(1'b1);
        check("t5 end busy", o_busy, 0);
        check("t5 end grant", o_grant, 0);
        check("t5 end s_trdy", s_axis_trdy, 0);
        exp_ord.push_back(1);
        check_stream("t5");

        // 6: reset on beat 5 of 10; afterwards rotation restarts from 0
        clear_log();
        len[2] = 10;
        frames_left[2] = 1;
        drive_src();
        tick(1'b1);
        for (int b = 0; b < 4; b++) tick(1'b1);
        check("t6 beat5", m_axis_tdata, mk(2, fidx[2], 4));
        i_reset_n = 1'b0;
        tick(1'b1);
        check("t6 rst tvalid", m_axis_tvalid, 0);
        check("t6 rst grant", o_grant, 0);
        check("t6 rst s_trdy", s_axis_trdy, 0);
        check("t6 rst busy", o_busy, 0);
        clear_log();
        len[1] = 2;
        frames_left[1] = 1;
        drive_src();
        i_reset_n = 1'b1;
        tick(1'b1);
        check("t6 rearb grant", o_grant, 4'b0010);
        run_idle("t6", 200);
        exp_ord.push_back(1); exp_ord.push_back(2);
        check_stream("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
